// File: rtl/jt12_slot_seq.sv
`default_nettype none
// ============================================================================
// Module   : jt12_slot_seq
// Brief    : YM2612 operator-slot sequencer. Steps through the 24 live slots
//            in chip order, tracks the frame position, and holds one pending
//            channel-register write until the sequencer reaches its slot.
// Revision : 1.0  initial release
// ============================================================================
module jt12_slot_seq #(
  parameter int DW    = 8,
  parameter int NSLOT = 24
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clk_en,
  input  logic          wr_req,
  input  logic [2:0]    wr_ch,
  input  logic [1:0]    wr_op,
  input  logic [DW-1:0] wr_data,
  output logic          wr_busy,
  output logic          wr_ack,
  output logic          wr_err,
  output logic [4:0]    cur_slot,
  output logic [2:0]    cur_ch,
  output logic [1:0]    cur_op,
  output logic          zero,
  output logic [4:0]    frame_cnt,
  output logic          upd_en,
  output logic [4:0]    upd_slot,
  output logic [DW-1:0] upd_data
);

  localparam logic [4:0] c_LAST = 5'(NSLOT - 1);

  logic [4:0]    r_slot;
  logic [4:0]    r_frame;
  logic          r_pend;
  logic [4:0]    r_lat_slot;
  logic [DW-1:0] r_lat_data;
  logic          r_ack;
  logic          r_err;
  logic [4:0]    r_upd_slot;
  logic [DW-1:0] r_upd_data;

  logic [2:0]    w_a;
  logic [2:0]    w_ch_nx;
  logic [1:0]    w_op_nx;
  logic          w_illegal;
  logic          w_accept;
  logic          w_reject;
  logic          w_release;

  // Next-slot arithmetic: channel codes 3 and 7 do not exist, so they are
  // hopped over; the operator field advances after the last channel (6).
  always_comb begin
    w_a       = r_slot[2:0] + 3'd1;
    w_ch_nx   = (w_a[1:0] == 2'b11) ? (w_a + 3'd1) : w_a;
    w_op_nx   = (r_slot[2:0] == 3'd6) ? (r_slot[4:3] + 2'd1) : r_slot[4:3];
    w_illegal = (wr_ch[1:0] == 2'b11);
    w_accept  = wr_req & ~r_pend & ~w_illegal;
    w_reject  = wr_req & ~r_pend &  w_illegal;
    // Compare against the pre-advance slot so the release lines up with the
    // data that downstream shift registers hold for that slot.
    w_release = clk_en & r_pend & (r_slot == r_lat_slot);
  end

  // Slot and frame position registers, advanced once per clk_en.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_slot  <= 5'd0;
      r_frame <= 5'd0;
    end else if (clk_en) begin
      r_slot  <= {w_op_nx, w_ch_nx};
      r_frame <= (r_frame == c_LAST) ? 5'd0 : (r_frame + 5'd1);
    end
  end

  // Single-entry write holding register. Accept and release are mutually
  // exclusive because accept needs the entry empty and release needs it full,
  // so a write accepted on its own slot edge waits for the next frame.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_pend     <= 1'b0;
      r_lat_slot <= 5'd0;
      r_lat_data <= '0;
      r_ack      <= 1'b0;
      r_err      <= 1'b0;
      r_upd_slot <= 5'd0;
      r_upd_data <= '0;
    end else begin
      r_ack <= w_release;
      r_err <= w_reject;
      if (w_accept) begin
        r_pend     <= 1'b1;
        r_lat_slot <= {wr_op, wr_ch};
        r_lat_data <= wr_data;
      end else if (w_release) begin
        r_pend     <= 1'b0;
        r_upd_slot <= r_lat_slot;
        r_upd_data <= r_lat_data;
      end
    end
  end

  // Frame counter and slot index must wrap together.
  a_frame_sync : assert property (@(posedge clk) disable iff (!rst_n)
    ((r_frame == 5'd0) == (r_slot == 5'd0)));

  assign cur_slot  = r_slot;
  assign cur_ch    = r_slot[2:0];
  assign cur_op    = r_slot[4:3];
  assign zero      = (r_slot == 5'd0);
  assign frame_cnt = r_frame;
  assign wr_busy   = r_pend;
  assign wr_ack    = r_ack;
  assign wr_err    = r_err;
  assign upd_en    = r_ack;
  assign upd_slot  = r_upd_slot;
  assign upd_data  = r_upd_data;

endmodule
`default_nettype wire

// File: tb/tb_jt12_slot_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_jt12_slot_seq
// Brief    : Directed self-checking bench for jt12_slot_seq.
// Revision : 1.0  initial release
// ============================================================================
module tb_jt12_slot_seq;

  logic       clk = 1'b0;
  logic       rst_n, clk_en, wr_req;
  logic [2:0] wr_ch;
  logic [1:0] wr_op;
  logic [7:0] wr_data;
  logic       wr_busy, wr_ack, wr_err, zero, upd_en;
  logic [4:0] cur_slot, frame_cnt, upd_slot;
  logic [2:0] cur_ch;
  logic [1:0] cur_op;
  logic [7:0] upd_data;

  int passed = 0;
  int total  = 0;

  logic [4:0] order [0:23] = '{5'd0, 5'd1, 5'd2, 5'd4, 5'd5, 5'd6, 5'd8, 5'd9,
                               5'd10, 5'd12, 5'd13, 5'd14, 5'd16, 5'd17, 5'd18, 5'd20,
                               5'd21, 5'd22, 5'd24, 5'd25, 5'd26, 5'd28, 5'd29, 5'd30};

  jt12_slot_seq #(.DW(8), .NSLOT(24)) dut (
    .clk(clk), .rst_n(rst_n), .clk_en(clk_en), .wr_req(wr_req),
    .wr_ch(wr_ch), .wr_op(wr_op), .wr_data(wr_data),
    .wr_busy(wr_busy), .wr_ack(wr_ack), .wr_err(wr_err),
    .cur_slot(cur_slot), .cur_ch(cur_ch), .cur_op(cur_op), .zero(zero),
    .frame_cnt(frame_cnt), .upd_en(upd_en), .upd_slot(upd_slot), .upd_data(upd_data)
  );

  always #5 clk = ~clk;

  // One clock: drive inputs, take the edge, sample 1 time unit later.
  task automatic step(input logic en, input logic req, input logic [2:0] ch,
                      input logic [1:0] op, input logic [7:0] d);
    clk_en = en; wr_req = req; wr_ch = ch; wr_op = op; wr_data = d;
    @(posedge clk);
    #1;
    clk_en = 1'b0; wr_req = 1'b0;
  endtask

  task automatic advance_to(input logic [4:0] target);
    for (int i = 0; i < 30 && cur_slot !== target; i++) step(1'b1, 1'b0, 3'd0, 2'd0, 8'd0);
    total++;
    if (cur_slot !== target) $display("FAIL advance_to: cur_slot=%0d required=%0d", cur_slot, target);
    else passed++;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    step(1'b0, 1'b0, 3'd0, 2'd0, 8'd0);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    total++;
    if ({cur_slot, frame_cnt, zero, wr_busy, wr_ack, wr_err, upd_en, upd_slot, upd_data} !==
        {5'd0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 8'd0})
      $display("FAIL reset_state: slot=%0d frame=%0d zero=%b busy=%b ack=%b err=%b upd=%b uslot=%0d udata=%h required 0,0,1,0,0,0,0,0,00",
               cur_slot, frame_cnt, zero, wr_busy, wr_ack, wr_err, upd_en, upd_slot, upd_data);
    else passed++;
  endtask

  task automatic test_sequence();
    logic [4:0] exp_slot;
    for (int k = 0; k <= 25; k++) begin
      if (k > 0) step(1'b1, 1'b0, 3'd0, 2'd0, 8'd0);
      exp_slot = order[k % 24];
      total++;
      if (cur_slot !== exp_slot || frame_cnt !== 5'(k % 24) || zero !== (exp_slot == 5'd0) ||
          cur_ch !== exp_slot[2:0] || cur_op !== exp_slot[4:3])
        $display("FAIL sequence[%0d]: slot=%0d frame=%0d zero=%b ch=%0d op=%0d required slot=%0d frame=%0d",
                 k, cur_slot, frame_cnt, zero, cur_ch, cur_op, exp_slot, k % 24);
      else passed++;
    end
  endtask

  task automatic test_hold();
    advance_to(5'd13);
    for (int i = 0; i < 10; i++) begin
      step(1'b0, 1'b0, 3'd0, 2'd0, 8'd0);
      total++;
      if (cur_slot !== 5'd13 || frame_cnt !== 5'd10 || zero !== 1'b0)
        $display("FAIL hold[%0d]: slot=%0d frame=%0d zero=%b required 13,10,0", i, cur_slot, frame_cnt, zero);
      else passed++;
    end
  endtask

  task automatic test_write();
    int fires = 0;
    advance_to(5'd0);
    step(1'b0, 1'b1, 3'd5, 2'd2, 8'hA5);
    total++;
    if (wr_busy !== 1'b1 || upd_en !== 1'b0) $display("FAIL write_busy: busy=%b upd=%b required 1,0", wr_busy, upd_en);
    else passed++;
    // slot 21 is index 16 of the order, so the 17th pulse has it as pre-edge slot
    for (int p = 1; p <= 30; p++) begin
      step(1'b1, 1'b0, 3'd0, 2'd0, 8'd0);
      if (upd_en === 1'b1) fires++;
      if (p == 17) begin
        total++;
        if ({upd_en, wr_ack, wr_busy, upd_slot, upd_data} !== {1'b1, 1'b1, 1'b0, 5'd21, 8'hA5})
          $display("FAIL write_release: upd=%b ack=%b busy=%b uslot=%0d udata=%h required 1,1,0,21,a5",
                   upd_en, wr_ack, wr_busy, upd_slot, upd_data);
        else passed++;
      end
      if (p == 18) begin
        total++;
        if ({upd_en, wr_ack, upd_slot, upd_data} !== {1'b0, 1'b0, 5'd21, 8'hA5})
          $display("FAIL write_after: upd=%b ack=%b uslot=%0d udata=%h required 0,0,21,a5",
                   upd_en, wr_ack, upd_slot, upd_data);
        else passed++;
      end
    end
    total++;
    if (fires !== 1) $display("FAIL write_fire_count: fires=%0d required 1", fires);
    else passed++;
  endtask

  task automatic test_illegal();
    int fires = 0;
    step(1'b0, 1'b1, 3'd3, 2'd1, 8'h11);
    total++;
    if (wr_err !== 1'b1 || wr_busy !== 1'b0) $display("FAIL illegal_err: err=%b busy=%b required 1,0", wr_err, wr_busy);
    else passed++;
    step(1'b0, 1'b0, 3'd0, 2'd0, 8'd0);
    total++;
    if (wr_err !== 1'b0) $display("FAIL illegal_err_pulse: err=%b required 0", wr_err);
    else passed++;
    step(1'b0, 1'b1, 3'd7, 2'd0, 8'h22);
    total++;
    if (wr_err !== 1'b1 || wr_busy !== 1'b0) $display("FAIL illegal_err7: err=%b busy=%b required 1,0", wr_err, wr_busy);
    else passed++;
    for (int p = 0; p < 30; p++) begin
      step(1'b1, 1'b0, 3'd0, 2'd0, 8'd0);
      if (upd_en === 1'b1 || wr_busy === 1'b1) fires++;
    end
    total++;
    if (fires !== 0) $display("FAIL illegal_no_update: events=%0d required 0", fires);
    else passed++;
  endtask

  task automatic test_same_edge();
    int fire_at = -1;
    advance_to(5'd9);
    step(1'b1, 1'b1, 3'd1, 2'd1, 8'h5A);
    total++;
    if (wr_busy !== 1'b1 || upd_en !== 1'b0) $display("FAIL same_edge_accept: busy=%b upd=%b required 1,0", wr_busy, upd_en);
    else passed++;
    for (int p = 1; p <= 30; p++) begin
      step(1'b1, 1'b0, 3'd0, 2'd0, 8'd0);
      if (upd_en === 1'b1 && fire_at < 0) fire_at = p;
    end
    total++;
    if (fire_at !== 24 || upd_slot !== 5'd9 || upd_data !== 8'h5A)
      $display("FAIL same_edge_latency: pulses=%0d uslot=%0d udata=%h required 24,9,5a", fire_at, upd_slot, upd_data);
    else passed++;
  endtask

  task automatic test_back_to_back();
    advance_to(5'd0);
    step(1'b0, 1'b1, 3'd2, 2'd0, 8'h3C);
    step(1'b0, 1'b1, 3'd6, 2'd3, 8'hFF);
    total++;
    if (wr_busy !== 1'b1 || wr_err !== 1'b0) $display("FAIL busy_ignore: busy=%b err=%b required 1,0", wr_busy, wr_err);
    else passed++;
    for (int p = 0; p < 3; p++) step(1'b1, 1'b0, 3'd0, 2'd0, 8'd0);
    total++;
    if ({upd_en, wr_ack, wr_busy, upd_slot, upd_data} !== {1'b1, 1'b1, 1'b0, 5'd2, 8'h3C})
      $display("FAIL busy_first_wins: upd=%b ack=%b busy=%b uslot=%0d udata=%h required 1,1,0,2,3c",
               upd_en, wr_ack, wr_busy, upd_slot, upd_data);
    else passed++;
    // new request while ack is high; current slot is 4, release on next pulse
    step(1'b0, 1'b1, 3'd4, 2'd0, 8'hC3);
    total++;
    if (wr_busy !== 1'b1 || upd_en !== 1'b0) $display("FAIL ack_cycle_accept: busy=%b upd=%b required 1,0", wr_busy, upd_en);
    else passed++;
    step(1'b1, 1'b0, 3'd0, 2'd0, 8'd0);
    total++;
    if ({upd_en, upd_slot, upd_data, wr_busy} !== {1'b1, 5'd4, 8'hC3, 1'b0})
      $display("FAIL min_latency: upd=%b uslot=%0d udata=%h busy=%b required 1,4,c3,0", upd_en, upd_slot, upd_data, wr_busy);
    else passed++;
  endtask

  task automatic test_reset_pending();
    int fires = 0;
    advance_to(5'd0);
    step(1'b0, 1'b1, 3'd6, 2'd3, 8'h77);
    for (int p = 0; p < 3; p++) step(1'b1, 1'b0, 3'd0, 2'd0, 8'd0);
    do_reset();
    total++;
    if ({cur_slot, frame_cnt, zero, wr_busy, wr_ack, wr_err, upd_en, upd_slot, upd_data} !==
        {5'd0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 8'd0})
      $display("FAIL reset_pending_state: slot=%0d frame=%0d zero=%b busy=%b ack=%b upd=%b uslot=%0d udata=%h required 0,0,1,0,0,0,0,00",
               cur_slot, frame_cnt, zero, wr_busy, wr_ack, upd_en, upd_slot, upd_data);
    else passed++;
    for (int p = 0; p < 30; p++) begin
      step(1'b1, 1'b0, 3'd0, 2'd0, 8'd0);
      if (upd_en === 1'b1 || wr_ack === 1'b1) fires++;
    end
    total++;
    if (fires !== 0) $display("FAIL reset_drops_write: events=%0d required 0", fires);
    else passed++;
  endtask

  initial begin
    rst_n = 1'b0; clk_en = 1'b0; wr_req = 1'b0; wr_ch = 3'd0; wr_op = 2'd0; wr_data = 8'd0;
    test_reset();
    test_sequence();
    test_hold();
    test_write();
    test_illegal();
    test_same_edge();
    test_back_to_back();
    test_reset_pending();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
`default_nettype wire
